// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store sequencer.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE0  = 3'd1,
    ST_ISSUE1  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } lsu_state_t;

  // Access size in bytes; 0 for encodings that carry no size.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3)
      LB, LBU: return 3'd1;
      LH, LHU: return 3'd2;
      LW:      return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic access_legal(input logic we, input logic [2:0] funct3);
    if (we) return (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
    return (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
           (funct3 == LBU) || (funct3 == LHU);
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Request, RAM and response signals of the load/store sequencer.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_* must hold stable while req_valid is high and req_ready is low.
// rsp_valid is a single-cycle pulse with no back-pressure.
interface mem_access_sequencer_if #(
  parameter int ADDR_W = 10
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_byteen;
  logic [31:0]       mem_wdata;
  logic              mem_wren;
  logic [31:0]       mem_rdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  // Environment side: execute stage plus RAM.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, mem_addr, mem_byteen, mem_wdata, mem_wren,
           rsp_valid, rsp_rdata, rsp_err
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, mem_addr, mem_byteen, mem_wdata, mem_wren,
           rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane mask generation, store data shift and load merge/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rword0,
  input  logic [31:0] rword1,
  output logic [3:0]  byteen0,
  output logic [3:0]  byteen1,
  output logic        split,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] rdata
);

  logic [2:0]  size;
  logic [5:0]  shamt;
  logic [7:0]  mask8;
  logic [63:0] w64;
  logic [63:0] r64;
  logic [31:0] low;

  always_comb begin
    size    = access_size(funct3);
    shamt   = {offset, 3'b000};
    // A mask spilling into bits [7:4] means the access crosses into the next word.
    mask8   = ((8'd1 << size) - 8'd1) << offset;
    byteen0 = mask8[3:0];
    byteen1 = mask8[7:4];
    split   = (mask8[7:4] != 4'b0000);

    w64     = {32'b0, wdata} << shamt;
    wdata0  = w64[31:0];
    wdata1  = w64[63:32];

    r64     = {rword1, rword0} >> shamt;
    low     = r64[31:0];
    rdata   = low;
    case (funct3)
      LB:      rdata = {{24{low[7]}}, low[7:0]};
      LH:      rdata = {{16{low[15]}}, low[15:0]};
      LBU:     rdata = {24'b0, low[7:0]};
      LHU:     rdata = {16'b0, low[15:0]};
      default: rdata = low;
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// One-at-a-time load/store sequencer in front of a single-port data RAM;
// word-crossing accesses become two RAM cycles.
module mem_access_sequencer
  import lsu_pkg::*;
#(
  parameter int ADDR_W           = 10,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_access_sequencer_if.slave  bus,
  output lsu_state_t             dbg_state
);

  lsu_state_t        state, state_nx;
  logic              req_we_q;
  logic [2:0]        req_f3_q;
  logic [31:0]       req_addr_q;
  logic [31:0]       req_wdata_q;
  logic              split_q;
  logic [31:0]       word0_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic              idle;
  logic [2:0]        al_f3;
  logic [1:0]        al_off;
  logic [31:0]       al_rword0;
  logic [31:0]       al_rword1;
  logic [3:0]        al_be0, al_be1;
  logic              al_split;
  logic [31:0]       al_wd0, al_wd1, al_rdata;
  logic              reject;
  logic [ADDR_W-1:0] word0_addr;
  logic [ADDR_W-1:0] word1_addr;

  // In IDLE the aligner looks at the live request so the split/reject
  // decision is made on the accept edge; afterwards it sees the latched copy.
  always_comb begin
    idle       = (state == ST_IDLE);
    al_f3      = idle ? bus.req_funct3 : req_f3_q;
    al_off     = idle ? bus.req_addr[1:0] : req_addr_q[1:0];
    al_rword0  = split_q ? word0_q : bus.mem_rdata;
    al_rword1  = split_q ? bus.mem_rdata : 32'b0;
    reject     = !access_legal(bus.req_we, bus.req_funct3) ||
                 (al_split && !ALLOW_MISALIGNED);
    word0_addr = req_addr_q[ADDR_W+1:2];
    word1_addr = word0_addr + ADDR_W'(1);
  end

  lsu_align u_align (
    .funct3  (al_f3),
    .offset  (al_off),
    .wdata   (req_wdata_q),
    .rword0  (al_rword0),
    .rword1  (al_rword1),
    .byteen0 (al_be0),
    .byteen1 (al_be1),
    .split   (al_split),
    .wdata0  (al_wd0),
    .wdata1  (al_wd1),
    .rdata   (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:
        if (bus.req_valid) state_nx = reject ? ST_RESP : ST_ISSUE0;
      ST_ISSUE0:
        if (split_q)       state_nx = ST_ISSUE1;
        else if (req_we_q) state_nx = ST_RESP;
        else               state_nx = ST_CAPTURE;
      ST_ISSUE1:  state_nx = req_we_q ? ST_RESP : ST_CAPTURE;
      ST_CAPTURE: state_nx = ST_RESP;
      ST_RESP:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // mem_wren is gated by rst so a reset landing on an issue cycle writes nothing.
  always_comb begin
    bus.req_ready  = idle;
    bus.rsp_valid  = (state == ST_RESP);
    bus.rsp_rdata  = rsp_rdata_q;
    bus.rsp_err    = rsp_err_q;
    bus.mem_addr   = '0;
    bus.mem_byteen = 4'b0000;
    bus.mem_wdata  = 32'b0;
    bus.mem_wren   = 1'b0;
    dbg_state      = state;
    case (state)
      ST_ISSUE0: begin
        bus.mem_addr   = word0_addr;
        bus.mem_byteen = al_be0;
        if (req_we_q) begin
          bus.mem_wdata = al_wd0;
          bus.mem_wren  = !rst;
        end
      end
      ST_ISSUE1: begin
        bus.mem_addr   = word1_addr;
        bus.mem_byteen = al_be1;
        if (req_we_q) begin
          bus.mem_wdata = al_wd1;
          bus.mem_wren  = !rst;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_we_q    <= 1'b0;
      req_f3_q    <= 3'b000;
      req_addr_q  <= 32'b0;
      req_wdata_q <= 32'b0;
      split_q     <= 1'b0;
      word0_q     <= 32'b0;
      rsp_rdata_q <= 32'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          rsp_rdata_q <= 32'b0;
          rsp_err_q   <= bus.req_valid && reject;
          if (bus.req_valid) begin
            req_we_q    <= bus.req_we;
            req_f3_q    <= bus.req_funct3;
            req_addr_q  <= bus.req_addr;
            req_wdata_q <= bus.req_wdata;
            split_q     <= al_split;
          end
        end
        // Read data for the word0 address issued last cycle arrives now.
        ST_ISSUE1:  if (!req_we_q) word0_q <= bus.mem_rdata;
        ST_CAPTURE: rsp_rdata_q <= al_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed table-driven bench for mem_access_sequencer with a byte-enabled RAM model.
module tb_mem_access_sequencer;
  import lsu_pkg::*;

  localparam int ADDR_W = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_sequencer_if #(.ADDR_W(ADDR_W)) bus ();
  mem_access_sequencer_if #(.ADDR_W(ADDR_W)) rbus ();
  lsu_state_t dbg_state;
  lsu_state_t rdbg_state;

  mem_access_sequencer #(.ADDR_W(ADDR_W), .ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  mem_access_sequencer #(.ADDR_W(ADDR_W), .ALLOW_MISALIGNED(1'b0)) u_rej (
    .clk       (clk),
    .rst       (rst),
    .bus       (rbus.slave),
    .dbg_state (rdbg_state)
  );

  // ---------------- RAM model (1-cycle read latency) ----------------
  logic [31:0]       ram [0:(1<<ADDR_W)-1];
  logic              pre_we;
  logic [ADDR_W-1:0] pre_addr;
  logic [31:0]       pre_data;

  always @(posedge clk) begin
    bus.mem_rdata <= ram[bus.mem_addr];
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.mem_wren)
      for (int b = 0; b < 4; b++)
        if (bus.mem_byteen[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
  end

  assign rbus.mem_rdata = 32'h0;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic              we;
    logic [2:0]        f3;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              pre;
    logic [31:0]       pre0;
    logic [31:0]       pre1;
    logic [ADDR_W-1:0] a1;
    logic [3:0]        be1;
    logic [31:0]       wd1;
    logic              wr1;
    logic [ADDR_W-1:0] a2;
    logic [3:0]        be2;
    logic [31:0]       wd2;
    logic              wr2;
    int                lat;
    logic [31:0]       rdata;
    logic              err;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [ADDR_W-1:0] w0a;
    logic [ADDR_W-1:0] a1, a2;
    logic [3:0]        be1, be2;
    logic [31:0]       wd1, wd2, rd;
    logic              wr1, wr2, er, extra;
    int                lat;
    w0a = v.addr[ADDR_W+1:2];
    if (v.pre) begin
      preload(w0a, v.pre0);
      preload(w0a + ADDR_W'(1), v.pre1);
    end
    @(negedge clk);
    check({tag, " ready"}, {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    @(posedge clk);
    lat = 0; rd = '0; er = 1'b0; extra = 1'b0;
    a1 = '0; a2 = '0; be1 = '0; be2 = '0; wd1 = '0; wd2 = '0; wr1 = 1'b0; wr2 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.req_valid = 1'b0;
        a1 = bus.mem_addr; be1 = bus.mem_byteen; wd1 = bus.mem_wdata; wr1 = bus.mem_wren;
      end
      if (k == 2) begin
        a2 = bus.mem_addr; be2 = bus.mem_byteen; wd2 = bus.mem_wdata; wr2 = bus.mem_wren;
      end
      if (lat != 0) begin
        extra = bus.rsp_valid;
        break;
      end
      if (bus.rsp_valid) begin
        lat = k; rd = bus.rsp_rdata; er = bus.rsp_err;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " rsp_rdata"}, rd, v.rdata);
    check({tag, " rsp_err"}, {31'b0, er}, {31'b0, v.err});
    check({tag, " pulse"}, {31'b0, extra}, 32'd0);
    check({tag, " c1 addr"}, 32'(a1), 32'(v.a1));
    check({tag, " c1 byteen"}, 32'(be1), 32'(v.be1));
    check({tag, " c1 wdata"}, wd1, v.wd1);
    check({tag, " c1 wren"}, {31'b0, wr1}, {31'b0, v.wr1});
    check({tag, " c2 addr"}, 32'(a2), 32'(v.a2));
    check({tag, " c2 byteen"}, 32'(be2), 32'(v.be2));
    check({tag, " c2 wdata"}, wd2, v.wd2);
    check({tag, " c2 wren"}, {31'b0, wr2}, {31'b0, v.wr2});
  endtask

  // Reject-instance transaction: returns latency, data, error and any write seen.
  task automatic run_rej(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                         output logic er, output logic wr_any);
    @(negedge clk);
    rbus.req_valid  = 1'b1;
    rbus.req_we     = we;
    rbus.req_funct3 = f3;
    rbus.req_addr   = addr;
    rbus.req_wdata  = wdata;
    @(posedge clk);
    lat = 0; rd = '0; er = 1'b0; wr_any = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      rbus.req_valid = 1'b0;
      wr_any |= rbus.mem_wren;
      if (rbus.rsp_valid && lat == 0) begin
        lat = k; rd = rbus.rsp_rdata; er = rbus.rsp_err;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er, wr_any;
    int          stray;

    //           we    f3    addr          wdata         pre   pre0          pre1          a1      be1      wd1           wr1   a2      be2      wd2           wr2   lat rdata         err
    vecs[0]  = '{1'b0, LW,  32'h0000_0100, 32'h0,        1'b1, 32'hDEADBEEF, 32'h0,        10'h040, 4'b1111, 32'h0,        1'b0, 10'h000, 4'b0000, 32'h0,        1'b0, 3, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b0, LB,  32'h0000_0103, 32'h0,        1'b1, 32'h80112233, 32'h0,        10'h040, 4'b1000, 32'h0,        1'b0, 10'h000, 4'b0000, 32'h0,        1'b0, 3, 32'hFFFFFF80, 1'b0};
    vecs[2]  = '{1'b0, LBU, 32'h0000_0103, 32'h0,        1'b0, 32'h0,        32'h0,        10'h040, 4'b1000, 32'h0,        1'b0, 10'h000, 4'b0000, 32'h0,        1'b0, 3, 32'h00000080, 1'b0};
    vecs[3]  = '{1'b1, SW,  32'h0000_0102, 32'h11223344, 1'b1, 32'h0,        32'h0,        10'h040, 4'b1100, 32'h33440000, 1'b1, 10'h041, 4'b0011, 32'h00001122, 1'b1, 3, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, LW,  32'h0000_0100, 32'h0,        1'b0, 32'h0,        32'h0,        10'h040, 4'b1111, 32'h0,        1'b0, 10'h000, 4'b0000, 32'h0,        1'b0, 3, 32'h33440000, 1'b0};
    vecs[5]  = '{1'b0, LW,  32'h0000_0104, 32'h0,        1'b0, 32'h0,        32'h0,        10'h041, 4'b1111, 32'h0,        1'b0, 10'h000, 4'b0000, 32'h0,        1'b0, 3, 32'h00001122, 1'b0};
    vecs[6]  = '{1'b0, LH,  32'h0000_0FFF, 32'h0,        1'b1, 32'h7F000000, 32'h00000080, 10'h3FF, 4'b1000, 32'h0,        1'b0, 10'h000, 4'b0001, 32'h0,        1'b0, 4, 32'hFFFF807F, 1'b0};
    vecs[7]  = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,     1'b0, 32'h0,        32'h0,        10'h000, 4'b0000, 32'h0,        1'b0, 10'h000, 4'b0000, 32'h0,        1'b0, 1, 32'h0,        1'b1};
    vecs[8]  = '{1'b1, SH,  32'h0000_0101, 32'hABCD1234, 1'b0, 32'h0,        32'h0,        10'h040, 4'b0110, 32'hCD123400, 1'b1, 10'h000, 4'b0000, 32'h0,        1'b0, 2, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, LHU, 32'h0000_0101, 32'h0,        1'b0, 32'h0,        32'h0,        10'h040, 4'b0110, 32'h0,        1'b0, 10'h000, 4'b0000, 32'h0,        1'b0, 3, 32'h00001234, 1'b0};
    vecs[10] = '{1'b1, 3'b100, 32'h0000_0200, 32'h5A5A5A5A, 1'b0, 32'h0,     32'h0,        10'h000, 4'b0000, 32'h0,        1'b0, 10'h000, 4'b0000, 32'h0,        1'b0, 1, 32'h0,        1'b1};
    vecs[11] = '{1'b0, LHU, 32'h0000_0103, 32'h0,        1'b1, 32'hAB000000, 32'h000000CD, 10'h040, 4'b1000, 32'h0,        1'b0, 10'h041, 4'b0001, 32'h0,        1'b0, 4, 32'h0000CDAB, 1'b0};
    vecs[12] = '{1'b1, SB,  32'h0000_01FE, 32'h000000A5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 10'h07F, 4'b0100, 32'h00A50000, 1'b1, 10'h000, 4'b0000, 32'h0,        1'b0, 2, 32'h0,        1'b0};
    vecs[13] = '{1'b0, LW,  32'h0000_01FC, 32'h0,        1'b0, 32'h0,        32'h0,        10'h07F, 4'b1111, 32'h0,        1'b0, 10'h000, 4'b0000, 32'h0,        1'b0, 3, 32'hFFA5FFFF, 1'b0};
    vecs[14] = '{1'b0, LB,  32'h0000_01FE, 32'h0,        1'b0, 32'h0,        32'h0,        10'h07F, 4'b0100, 32'h0,        1'b0, 10'h000, 4'b0000, 32'h0,        1'b0, 3, 32'hFFFFFFA5, 1'b0};

    rst = 1'b1;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0; bus.req_addr = '0; bus.req_wdata = '0;
    rbus.req_valid = 1'b0; rbus.req_we = 1'b0; rbus.req_funct3 = 3'b0; rbus.req_addr = '0; rbus.req_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state, observed while rst is still high.
    check("rst state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    check("rst byteen", 32'(bus.mem_byteen), 32'd0);
    check("rst wren", {31'b0, bus.mem_wren}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset landing on the first issue cycle of a store.
    preload(10'h042, 32'h12345678);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = SW;
    bus.req_addr = 32'h0000_0108; bus.req_wdata = 32'h00000055;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rstmid state", 32'(dbg_state), 32'(ST_ISSUE0));
    check("rstmid wren before", {31'b0, bus.mem_wren}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid wren gated", {31'b0, bus.mem_wren}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) stray++;
    end
    check("rstmid no rsp", 32'(stray), 32'd0);
    check("rstmid ram kept", ram[10'h042], 32'h12345678);
    run_vec('{1'b0, LW, 32'h0000_0108, 32'h0, 1'b0, 32'h0, 32'h0, 10'h042, 4'b1111, 32'h0, 1'b0,
              10'h000, 4'b0000, 32'h0, 1'b0, 3, 32'h12345678, 1'b0}, "after_rst");

    // Misalignment rejected when splitting is disabled.
    run_rej(1'b1, SW, 32'h0000_0101, 32'hFFFFFFFF, lat, rd, er, wr_any);
    check("rej sw lat", 32'(lat), 32'd1);
    check("rej sw err", {31'b0, er}, 32'd1);
    check("rej sw rdata", rd, 32'd0);
    check("rej sw wren", {31'b0, wr_any}, 32'd0);
    run_rej(1'b1, SW, 32'h0000_0100, 32'h01020304, lat, rd, er, wr_any);
    check("rej aligned lat", 32'(lat), 32'd2);
    check("rej aligned err", {31'b0, er}, 32'd0);
    check("rej aligned wren", {31'b0, wr_any}, 32'd1);
    run_rej(1'b0, LH, 32'h0000_0103, 32'h0, lat, rd, er, wr_any);
    check("rej lh lat", 32'(lat), 32'd1);
    check("rej lh err", {31'b0, er}, 32'd1);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
